// File: rtl/sample_capture.sv
// sample_capture: triggered acquisition buffer feeding the waveform display.
// Samples stream into a circular history. After a level/slope trigger the
// post-trigger window is captured. The linearised record is then copied into
// data_display during vertical blanking, so the trace only changes between frames.
// Optional feature macro: SAMPLE_CAPTURE_AUTO_TRIG_EN (forced trigger after
// AUTO_TIMEOUT valid samples spent in ARMED).
//
// Handshake: adc_valid is a valid-only strobe with no ready. Each cycle with
// adc_valid high carries one sample in adc_data. Samples that arrive in
// WAIT_VB or COPY are dropped. Cycles with adc_valid low change nothing.
module sample_capture #(
  parameter int DEPTH        = 256,
  parameter int PRE_TRIG     = 32,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] adc_data,
  input  logic        adc_valid,
  input  logic [11:0] trig_level,
  input  logic        trig_slope,
  input  logic        vblnk,
  output logic [11:0] data_display [0:DEPTH-1],
  output logic        triggered,
  output logic        capture_done,
  output logic [2:0]  state_dbg
);

  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam int POST_LEN = DEPTH - PRE_TRIG;
  localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(PRE_TRIG - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_LEN - 1);
  localparam logic [CNT_W-1:0] COPY_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_FILL    = 3'd0,
    S_ARMED   = 3'd1,
    S_POST    = 3'd2,
    S_WAIT_VB = 3'd3,
    S_COPY    = 3'd4
  } state_t;

  state_t state, state_next;

  logic [11:0]      sample_buf [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] start;
  logic [PTR_W-1:0] copy_addr;
  logic [CNT_W-1:0] cnt;
  logic [11:0]      prev;
  logic             vblnk_d;
  logic             take;
  logic             trig_hit;
  logic             level_hit;
  logic             auto_fire;

  assign state_dbg = state;
  assign copy_addr = start + cnt[PTR_W-1:0];

  // Level crossing relative to the previous accepted sample (unsigned compare).
  assign level_hit = trig_slope ? (prev > trig_level && adc_data <= trig_level)
                                : (prev < trig_level && adc_data >= trig_level);

`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
  localparam int AUTO_W = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_TIMEOUT - 1);
  logic [AUTO_W-1:0] auto_cnt;

  assign auto_fire = (auto_cnt == AUTO_LAST);

  // Count valid samples spent in ARMED; any other state holds the count at zero.
  always_ff @(posedge clk) begin
    if (rst || state != S_ARMED) auto_cnt <= '0;
    else if (adc_valid)          auto_cnt <= auto_cnt + AUTO_W'(1);
  end
`else
  // Timeout not built: ARMED waits for a real crossing, so AUTO_TIMEOUT has no effect.
  localparam bit AUTO_PRESENT = (AUTO_TIMEOUT < 0);
  assign auto_fire = AUTO_PRESENT;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= state_next;
  end

  // Next-state logic, plus the sample-accept and trigger strobes.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    trig_hit   = 1'b0;
    case (state)
      S_FILL: begin
        if (adc_valid) begin
          take = 1'b1;
          if (cnt == FILL_LAST) state_next = S_ARMED;
        end
      end
      S_ARMED: begin
        if (adc_valid) begin
          take     = 1'b1;
          trig_hit = level_hit | auto_fire;
          if (trig_hit) state_next = (POST_LEN == 1) ? S_WAIT_VB : S_POST;
        end
      end
      S_POST: begin
        if (adc_valid) begin
          take = 1'b1;
          if (cnt == POST_LAST) state_next = S_WAIT_VB;
        end
      end
      S_WAIT_VB: begin
        if (vblnk && !vblnk_d) state_next = S_COPY;
      end
      S_COPY: begin
        if (cnt == COPY_LAST) state_next = S_FILL;
      end
      default: state_next = S_FILL;
    endcase
  end

  // Circular history storage. Its contents are never reset.
  always_ff @(posedge clk) begin
    if (take) sample_buf[wr_ptr] <= adc_data;
  end

  // Pointers, counter, trigger flag and the display copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      start        <= '0;
      cnt          <= '0;
      prev         <= '0;
      vblnk_d      <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
      for (int i = 0; i < DEPTH; i++) data_display[i] <= '0;
    end else begin
      vblnk_d      <= vblnk;
      capture_done <= 1'b0;
      if (take) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
        prev   <= adc_data;
      end
      // The slot after the last post sample is the oldest sample of the record.
      if (take && state_next == S_WAIT_VB) start <= wr_ptr + PTR_W'(1);
      case (state)
        S_FILL: begin
          if (take) cnt <= (state_next == S_ARMED) ? '0 : cnt + CNT_W'(1);
        end
        S_ARMED: begin
          if (trig_hit) begin
            cnt       <= CNT_W'(1);
            triggered <= 1'b1;
          end
        end
        S_POST: begin
          if (take) cnt <= cnt + CNT_W'(1);
        end
        S_WAIT_VB: begin
          if (state_next == S_COPY) cnt <= '0;
        end
        S_COPY: begin
          data_display[cnt[PTR_W-1:0]] <= sample_buf[copy_addr];
          if (state_next == S_FILL) begin
            cnt          <= '0;
            triggered    <= 1'b0;
            capture_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture: randomized stimulus against a record-level reference model.
// The model scans the list of accepted samples for the first trigger position.
// It then predicts the displayed record as the DEPTH-sample slice around that position.
module tb_sample_capture;

  localparam int DEPTH        = 256;
  localparam int PRE_TRIG     = 32;
  localparam int AUTO_TIMEOUT = 4096;
  localparam int POST_LEN     = DEPTH - PRE_TRIG;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [11:0] trig_level = '0;
  logic        trig_slope = 1'b0;
  logic        vblnk = 1'b0;
  logic [11:0] data_display [0:DEPTH-1];
  logic        triggered;
  logic        capture_done;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  sample_capture #(
    .DEPTH(DEPTH), .PRE_TRIG(PRE_TRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .adc_data(adc_data), .adc_valid(adc_valid),
    .trig_level(trig_level), .trig_slope(trig_slope),
    .vblnk(vblnk),
    .data_display(data_display),
    .triggered(triggered), .capture_done(capture_done),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] stim [$];
  logic [11:0] tlevel;
  logic        tslope;
  int          trig_idx;
  logic [11:0] exp_q [$];
  logic [11:0] exp_disp [DEPTH];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_display(input string tag);
    for (int k = 0; k < DEPTH; k++)
      check_eq($sformatf("%s[%0d]", tag, k), 32'(data_display[k]), 32'(exp_disp[k]));
  endtask

  // Reference model: first accepted-sample index that triggers, or -1.
  // Samples 0..PRE_TRIG-1 fill the history; later ones are armed.
  function automatic int find_trigger();
    for (int i = PRE_TRIG; i < stim.size(); i++) begin
      bit hit;
      hit = tslope ? (stim[i-1] > tlevel && stim[i] <= tlevel)
                   : (stim[i-1] < tlevel && stim[i] >= tlevel);
`ifdef SAMPLE_CAPTURE_AUTO_TRIG_EN
      if (i - PRE_TRIG + 1 == AUTO_TIMEOUT) hit = 1'b1;
`endif
      if (hit) return i;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; adc_valid = 1'b0; vblnk = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One accepted sample, preceded by random idle cycles carrying junk data.
  task automatic drive_sample(input logic [11:0] d);
    while ($urandom_range(0, 3) == 0) begin
      adc_valid = 1'b0;
      adc_data  = 12'($urandom);
      @(posedge clk); #1;
    end
    adc_valid = 1'b1;
    adc_data  = d;
    @(posedge clk); #1;
    adc_valid = 1'b0;
  endtask

  // Feed stim, then run the vblank copy and score the displayed record.
  // hold_vb: vblnk is already high when capture ends. rst_k >= 0: reset at copy entry rst_k.
  task automatic run_record(input bit hold_vb, input int rst_k);
    int n;
    bit seen;
    trig_idx = find_trigger();
    if (trig_idx >= 0)
      while (stim.size() < trig_idx + POST_LEN + 8) stim.push_back(12'($urandom));
    exp_q.delete();
    if (trig_idx >= 0)
      for (int k = 0; k < DEPTH; k++) exp_q.push_back(stim[trig_idx - PRE_TRIG + k]);
    trig_level = tlevel;
    trig_slope = tslope;
    vblnk      = hold_vb;
    for (int i = 0; i < stim.size(); i++) begin
      drive_sample(stim[i]);
      check_eq("triggered", 32'(triggered), 32'(trig_idx >= 0 && i >= trig_idx));
    end
    check_eq("done_idle", 32'(capture_done), 32'(0));
    check_display("pre_copy");
    if (hold_vb) begin
      repeat (20) begin
        @(posedge clk); #1;
        check_eq("hold_done", 32'(capture_done), 32'(0));
      end
      check_display("hold_disp");
      vblnk = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
    end else begin
      repeat ($urandom_range(0, 5)) begin @(posedge clk); #1; end
    end
    vblnk = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < DEPTH + 20) begin
      @(posedge clk); #1;
      n++;
      if (n == 4) vblnk = 1'b0;
      seen = capture_done;
      if (rst_k >= 0 && n == rst_k + 1) begin
        check_eq("part_new", 32'(data_display[rst_k-1]), 32'(exp_q[rst_k-1]));
        check_eq("part_old", 32'(data_display[rst_k]), 32'(exp_disp[rst_k]));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("rst_trig", 32'(triggered), 32'(0));
        check_eq("rst_done", 32'(capture_done), 32'(0));
        check_eq("rst_state_fill", 32'(state_dbg), 32'(0));
        for (int k = 0; k < DEPTH; k++) exp_disp[k] = '0;
        check_display("rst_copy");
        vblnk = 1'b0;
        return;
      end
    end
    if (trig_idx >= 0) begin
      check_eq("done_seen", 32'(seen), 32'(1));
      check_eq("copy_cycles", 32'(n), 32'(DEPTH + 1));
      check_eq("trig_clear", 32'(triggered), 32'(0));
      for (int k = 0; k < DEPTH; k++) exp_disp[k] = exp_q.pop_front();
      check_display("record");
      @(posedge clk); #1;
      check_eq("done_pulse", 32'(capture_done), 32'(0));
    end else begin
      check_eq("no_done", 32'(seen), 32'(0));
      check_display("no_record");
    end
    vblnk = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    do_reset();
    check_eq("reset_trig", 32'(triggered), 32'(0));
    check_eq("reset_done", 32'(capture_done), 32'(0));
    check_eq("reset_state_fill", 32'(state_dbg), 32'(0));
    for (int k = 0; k < DEPTH; k++) exp_disp[k] = '0;
    check_display("reset_disp");

    // Rising ramp through 0x800.
    stim.delete();
    for (int i = 0; i < 600; i++) stim.push_back(12'(i * 16));
    tlevel = 12'h800; tslope = 1'b0;
    run_record(1'b0, -1);
    check_eq("ramp_d32", 32'(data_display[32]), 32'h800);
    check_eq("ramp_d31", 32'(data_display[31]), 32'h7F0);

    // Falling ramp from 0xFFF: first value at or below 0x800 is 0x7FF.
    stim.delete();
    for (int i = 0; i < 600; i++) stim.push_back(12'hFFF - 12'(i * 16));
    tlevel = 12'h800; tslope = 1'b1;
    run_record(1'b0, -1);
    check_eq("fall_d32", 32'(data_display[32]), 32'h7FF);
    check_eq("fall_d0", 32'(data_display[0]), 32'h9FF);

    // Back-to-back random records, random level and slope.
    repeat (4) begin
      stim.delete();
      for (int i = 0; i < 700; i++) stim.push_back(12'($urandom));
      tlevel = 12'($urandom_range(12'h100, 12'hEFF));
      tslope = 1'($urandom_range(0, 1));
      run_record(1'b0, -1);
    end

    // vblnk already high when capture completes.
    stim.delete();
    for (int i = 0; i < 700; i++) stim.push_back(12'($urandom));
    tlevel = 12'($urandom_range(12'h100, 12'hEFF));
    tslope = 1'($urandom_range(0, 1));
    run_record(1'b1, -1);

    // Reset in the middle of the copy, then a fresh record.
    stim.delete();
    for (int i = 0; i < 600; i++) stim.push_back(12'(i * 16));
    tlevel = 12'h800; tslope = 1'b0;
    run_record(1'b0, 100);
    stim.delete();
    for (int i = 0; i < 700; i++) stim.push_back(12'($urandom));
    tlevel = 12'($urandom_range(12'h100, 12'hEFF));
    tslope = 1'($urandom_range(0, 1));
    run_record(1'b0, -1);

    // Constant input below the level: no trigger unless the timeout is built.
    do_reset();
    for (int k = 0; k < DEPTH; k++) exp_disp[k] = '0;
    stim.delete();
    for (int i = 0; i < 10000; i++) stim.push_back(12'h400);
    tlevel = 12'h800; tslope = 1'b0;
    run_record(1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
